cmp_result_packer: RTL

//  Downstream of the SEL-driven N-bit compare stage: takes its 1-bit result stream
//  (one result per accepted beat) and packs results LSB-first into WORD_W-bit words.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/cmp_popcount.sv | 18 +
 rtl/cmp_result_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare stage and its result packer.
// Provides the default word width, the count-width helper and the
// SEL encodings of the upstream compare stage for use by benches.
package cmp_pkg;

  localparam int unsigned CMP_WORD_W = 8;
  localparam int unsigned CMP_TOT_W  = 16;

  // SEL encodings of the upstream N-bit compare stage
  localparam logic [2:0] CMP_SEL_EQ = 3'b010;
  localparam logic [2:0] CMP_SEL_GT = 3'b111;

  // Bits needed to hold a count in the range 0..w
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cmp_popcount.sv
// Combinational ones counter over a WORD_W-bit word.
// Ports: data_i - word to count; ones_o - number of set bits (0..WORD_W).
module cmp_popcount #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic [WORD_W-1:0] data_i,
  output logic [CNT_W-1:0]  ones_o
);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ones_o = ones_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/cmp_result_packer.sv
// Packs the 1-bit compare result stream LSB-first into WORD_W-bit words.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - result handshake (in_ready is combinational)
//   in_bit, in_last          - result bit; in_last closes the word after it
//   flush                    - close a partial word without a new bit
//   out_valid/out_ready      - packed word handshake
//   out_data/out_count/out_ones - word, valid bit count, ones count
//   true_total               - saturating count of accepted 1 results
module cmp_result_packer
  import cmp_pkg::*;
#(
  parameter int unsigned WORD_W = CMP_WORD_W,
  parameter int unsigned TOT_W  = CMP_TOT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bit,
  input  logic                       in_last,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic [cnt_w(WORD_W)-1:0]   out_count,
  output logic [cnt_w(WORD_W)-1:0]   out_ones,
  output logic [TOT_W-1:0]           true_total
);

  localparam int unsigned CNT_W = cnt_w(WORD_W);
  localparam int unsigned ACC_W = $clog2(WORD_W);
  localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(WORD_W - 1);
  localparam logic [TOT_W-1:0] TOT_MAX  = '1;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic [CNT_W-1:0]  out_ones_q, out_ones_d;
  logic [TOT_W-1:0]  total_q, total_d;

  logic              pop_c, accept_c, close_c, flush_mv_c, load_c;
  logic [WORD_W-1:0] word_c;
  logic [CNT_W-1:0]  count_c, ones_c;

  // Output register is free when empty or being popped this cycle
  assign in_ready = !out_valid_q || out_ready;

  cmp_popcount #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .data_i (word_c),
    .ones_o (ones_c)
  );

  // Candidate word (accumulator plus any bit accepted now) and next state
  always_comb begin
    pop_c      = out_valid_q && out_ready;
    accept_c   = in_valid && in_ready;
    word_c     = acc_q;
    count_c    = CNT_W'(acc_cnt_q);
    if (accept_c) begin
      word_c  = acc_q | (WORD_W'(in_bit) << acc_cnt_q);
      count_c = CNT_W'(acc_cnt_q) + CNT_W'(1);
    end
    // A flush alongside an accepted bit acts as in_last for that bit
    close_c    = accept_c && ((acc_cnt_q == LAST_IDX) || in_last || flush);
    flush_mv_c = flush && !accept_c && (acc_cnt_q != '0) && in_ready;
    load_c     = close_c || flush_mv_c;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ones_d  = out_ones_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    total_d     = total_q;

    // Load wins over pop so a same-cycle pop and completion has no bubble
    if (load_c) begin
      out_valid_d = 1'b1;
      out_data_d  = word_c;
      out_count_d = count_c;
      out_ones_d  = ones_c;
    end else if (pop_c) begin
      out_valid_d = 1'b0;
    end

    if (load_c) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end else if (accept_c) begin
      acc_d     = word_c;
      acc_cnt_d = acc_cnt_q + ACC_W'(1);
    end

    if (accept_c && in_bit && (total_q != TOT_MAX)) begin
      total_d = total_q + TOT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ones_q  <= '0;
      total_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ones_q  <= out_ones_d;
      total_q     <= total_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_count  = out_count_q;
  assign out_ones   = out_ones_q;
  assign true_total = total_q;

endmodule
